// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: MIPS coprocessor-0 register file and exception responder.
// Sits at the memory stage. Arbitrates exception priority for the instruction
// presented there, updates BadVAddr/Count/Compare/Status/Cause/EPC, and raises
// a one-cycle flush with the redirect PC for a taken exception or eret.
//
// Optional feature: define CP0_TIMER_EN to build Count, Compare, the Count
// half-rate toggle, Cause.TI and the timer contribution to Cause.IP[7].
// Without it Count/Compare read 0, ignore writes, and timer_int is 0.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   stall               memory stage held; blocks exception/eret/MTC0 effects
//   pc, in_delay_slot   memory-stage instruction PC and delay-slot flag
//   bad_addr            load/store data address (for BadVAddr)
//   int_hw[5:0]         external interrupt lines
//   adel_if..ades, eret per-instruction exception flags, eret request
//   cp0we/waddr/wdata   MTC0 write port
//   raddr/rdata         MFC0 read port (combinational, write-forwarded)
//   flush, newpc        pipeline flush and redirect target
//   status_o, cause_o, epc_o, timer_int   current register views
module cp0_exc_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] pc,
    input  logic        in_delay_slot,
    input  logic [31:0] bad_addr,
    input  logic [5:0]  int_hw,
    input  logic        adel_if,
    input  logic        ri,
    input  logic        ov,
    input  logic        syscall,
    input  logic        breakM,
    input  logic        adel,
    input  logic        ades,
    input  logic        eret,
    input  logic        cp0we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    output logic        flush,
    output logic [31:0] newpc,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int
);

    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_COUNT    = 5'd9;
    localparam logic [4:0] A_COMPARE  = 5'd11;
    localparam logic [4:0] A_STATUS   = 5'd12;
    localparam logic [4:0] A_CAUSE    = 5'd13;
    localparam logic [4:0] A_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [7:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;

    logic        int_pend, exc_any, exc_taken, eret_taken, mtc0_en, wr_ok;
    logic        bv_from_pc, bv_from_addr;
    logic [4:0]  exc_code;
    logic [31:0] count_rd, compare_rd, status_rd, cause_rd;

    // Exception arbitration: first matching source wins.
    always_comb begin
        int_pend     = ie_q & ~exl_q & (|(ip_q & im_q));
        exc_any      = 1'b1;
        exc_code     = EXC_INT;
        bv_from_pc   = 1'b0;
        bv_from_addr = 1'b0;
        if (int_pend)     exc_code = EXC_INT;
        else if (adel_if) begin exc_code = EXC_ADEL; bv_from_pc = 1'b1; end
        else if (ri)      exc_code = EXC_RI;
        else if (ov)      exc_code = EXC_OV;
        else if (syscall) exc_code = EXC_SYS;
        else if (breakM)  exc_code = EXC_BP;
        else if (adel)    begin exc_code = EXC_ADEL; bv_from_addr = 1'b1; end
        else if (ades)    begin exc_code = EXC_ADES; bv_from_addr = 1'b1; end
        else              exc_any = 1'b0;
    end

    assign exc_taken  = exc_any & ~stall;
    assign eret_taken = eret & ~exc_any & ~stall;
    assign flush      = exc_taken | eret_taken;
    assign newpc      = exc_taken ? EXC_VECTOR : (eret_taken ? epc_q : 32'h0);
    // An MTC0 is dropped whenever the instruction is flushed or held.
    assign mtc0_en    = cp0we & ~stall & ~exc_any & ~eret;

    always_comb begin
        case (waddr)
            A_STATUS, A_CAUSE, A_EPC: wr_ok = 1'b1;
`ifdef CP0_TIMER_EN
            A_COUNT, A_COMPARE:       wr_ok = 1'b1;
`endif
            default:                  wr_ok = 1'b0;
        endcase
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tick_q, tick_d;
    logic        ti_q, ti_d;

    // Count advances on every second cycle, independent of stall.
    always_comb begin
        tick_d    = ~tick_q;
        count_d   = count_q + {31'b0, tick_q};
        compare_d = compare_q;
        ti_d      = ti_q | ((count_q == compare_q) && (compare_q != 32'h0));
        if (mtc0_en && waddr == A_COUNT) begin
            count_d = wdata;
            tick_d  = 1'b0;
        end
        if (mtc0_en && waddr == A_COMPARE) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            tick_q    <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tick_q    <= tick_d;
            ti_q      <= ti_d;
        end
    end

    assign timer_int  = ti_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign timer_int  = 1'b0;
    assign count_rd   = 32'h0;
    assign compare_rd = 32'h0;
`endif

    always_comb begin
        badvaddr_d = badvaddr_q;
        epc_d      = epc_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        // Hardware IP bits track the lines every cycle; IP[1:0] are software.
        ip_d       = {int_hw[5] | timer_int, int_hw[4:0], ip_q[1:0]};
        if (exc_taken) begin
            exl_d     = 1'b1;
            exccode_d = exc_code;
            // A nested exception keeps the original return point.
            if (!exl_q) begin
                epc_d = in_delay_slot ? (pc - 32'd4) : pc;
                bd_d  = in_delay_slot;
            end
            if (bv_from_pc)        badvaddr_d = pc;
            else if (bv_from_addr) badvaddr_d = bad_addr;
        end else if (eret_taken) begin
            exl_d = 1'b0;
        end else if (mtc0_en) begin
            case (waddr)
                A_STATUS: begin
                    im_d  = wdata[15:8];
                    exl_d = wdata[1];
                    ie_d  = wdata[0];
                end
                A_CAUSE: ip_d[1:0] = wdata[9:8];
                A_EPC:   epc_d     = wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_q <= '0;
            epc_q      <= '0;
            im_q       <= STATUS_RST[15:8];
            exl_q      <= STATUS_RST[1];
            ie_q       <= STATUS_RST[0];
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exccode_q  <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            epc_q      <= epc_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exccode_q  <= exccode_d;
        end
    end

    assign status_rd = {STATUS_RST[31:16], im_q, STATUS_RST[7:2], exl_q, ie_q};
    assign cause_rd  = {bd_q, timer_int, 14'b0, ip_q, 1'b0, exccode_q, 2'b00};
    assign status_o  = status_rd;
    assign cause_o   = cause_rd;
    assign epc_o     = epc_q;

    // MFC0 sees an MTC0 to the same register in the same cycle.
    always_comb begin
        case (raddr)
            A_BADVADDR: rdata = badvaddr_q;
            A_COUNT:    rdata = count_rd;
            A_COMPARE:  rdata = compare_rd;
            A_STATUS:   rdata = status_rd;
            A_CAUSE:    rdata = cause_rd;
            A_EPC:      rdata = epc_q;
            default:    rdata = 32'h0;
        endcase
        if (mtc0_en && wr_ok && (waddr == raddr)) rdata = wdata;
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST = 32'h0040_0000;
    localparam logic [31:0] SMASK = 32'h0000_FF03;
    localparam logic [31:0] CMASK = 32'h0000_0300;
`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif
    localparam logic [4:0] PRIO_CODE [0:7] =
        '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05};

    logic        clk = 1'b0;
    logic        rst, stall, in_delay_slot;
    logic [31:0] pc, bad_addr, wdata;
    logic [5:0]  int_hw;
    logic        adel_if, ri, ov, syscall, breakM, adel, ades, eret, cp0we;
    logic [4:0]  waddr, raddr;
    logic [31:0] rdata, newpc, status_o, cause_o, epc_o;
    logic        flush, timer_int;

    int n_tests = 0;
    int n_fail  = 0;

    cp0_exc_unit #(.EXC_VECTOR(EXC_VECTOR), .STATUS_RST(STATUS_RST)) dut (
        .clk(clk), .rst(rst), .stall(stall), .pc(pc), .in_delay_slot(in_delay_slot),
        .bad_addr(bad_addr), .int_hw(int_hw), .adel_if(adel_if), .ri(ri), .ov(ov),
        .syscall(syscall), .breakM(breakM), .adel(adel), .ades(ades), .eret(eret),
        .cp0we(cp0we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata),
        .flush(flush), .newpc(newpc), .status_o(status_o), .cause_o(cause_o),
        .epc_o(epc_o), .timer_int(timer_int)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural registers held as full 32-bit words.
    logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
    bit          m_half;
    bit          started = 1'b0;

    // Index into the priority list of the winning exception, -1 when none.
    function automatic int m_sel();
        bit [7:0] f;
        f[0] = m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h00);
        f[1] = adel_if; f[2] = ri;     f[3] = ov;   f[4] = syscall;
        f[5] = breakM;  f[6] = adel;   f[7] = ades;
        for (int i = 0; i < 8; i++) if (f[i]) return i;
        return -1;
    endfunction

    function automatic bit m_writable(input logic [4:0] a);
        return (a == 5'd12) || (a == 5'd13) || (a == 5'd14) ||
               (TIMER && ((a == 5'd9) || (a == 5'd11)));
    endfunction

    function automatic logic [31:0] m_reg(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return TIMER ? m_count : 32'h0;
            5'd11:   return TIMER ? m_compare : 32'h0;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_update();
        int sel;
        bit ex, er, ti_old, nh;
        logic [31:0] ns, nc, ne, nb, ncount, ncmp;
        if (rst) begin
            m_status <= STATUS_RST; m_cause <= '0; m_epc <= '0; m_badv <= '0;
            m_count <= '0; m_compare <= '0; m_half <= 1'b0;
            return;
        end
        sel = m_sel();
        ex  = (sel >= 0) && !stall;
        er  = eret && (sel < 0) && !stall;
        ns = m_status; nc = m_cause; ne = m_epc; nb = m_badv;
        ncount = m_count; ncmp = m_compare; nh = m_half;
        ti_old = m_cause[30];
        if (TIMER) begin
            if (m_count == m_compare && m_compare != 32'h0) nc[30] = 1'b1;
            ncount = m_count + {31'b0, m_half};
            nh = !m_half;
        end
        nc[15:10] = {int_hw[5] | ti_old, int_hw[4:0]};
        if (ex) begin
            ns[1] = 1'b1;
            nc[6:2] = PRIO_CODE[sel];
            if (!m_status[1]) begin
                ne = in_delay_slot ? pc - 32'd4 : pc;
                nc[31] = in_delay_slot;
            end
            if (sel == 1) nb = pc;
            else if (sel == 6 || sel == 7) nb = bad_addr;
        end else if (er) begin
            ns[1] = 1'b0;
        end else if (cp0we && !stall && m_writable(waddr)) begin
            case (waddr)
                5'd9:    begin ncount = wdata; nh = 1'b0; end
                5'd11:   begin ncmp = wdata; nc[30] = 1'b0; end
                5'd12:   ns = (STATUS_RST & ~SMASK) | (wdata & SMASK);
                5'd13:   nc = (nc & ~CMASK) | (wdata & CMASK);
                default: ne = wdata;
            endcase
        end
        m_status <= ns; m_cause <= nc; m_epc <= ne; m_badv <= nb;
        m_count <= ncount; m_compare <= ncmp; m_half <= nh;
    endtask

    task automatic m_check();
        int sel;
        bit exp_flush;
        logic [31:0] exp_rd;
        sel = m_sel();
        exp_flush = !stall && (sel >= 0 || eret);
        chk("flush", {31'b0, flush}, {31'b0, exp_flush});
        if (exp_flush) chk("newpc", newpc, (sel >= 0) ? EXC_VECTOR : m_epc);
        if (cp0we && !stall && !(sel >= 0 || eret) && m_writable(waddr) && waddr == raddr)
            exp_rd = wdata;
        else
            exp_rd = m_reg(raddr);
        chk("rdata", rdata, exp_rd);
        chk("status_o", status_o, m_status);
        chk("cause_o", cause_o, m_cause);
        chk("epc_o", epc_o, m_epc);
        chk("timer_int", {31'b0, timer_int}, {31'b0, m_cause[30]});
    endtask

    always @(posedge clk) begin
        m_update();
        started <= 1'b1;
    end

    always @(negedge clk) if (started) m_check();

    task automatic clr();
        stall = 0; pc = 0; in_delay_slot = 0; bad_addr = 0; int_hw = 0;
        adel_if = 0; ri = 0; ov = 0; syscall = 0; breakM = 0; adel = 0; ades = 0;
        eret = 0; cp0we = 0; waddr = 0; wdata = 0; raddr = 0;
    endtask

    task automatic edge_();
        @(posedge clk); #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0we = 1; waddr = a; wdata = d;
        edge_();
        clr();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        clr();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        raddr = 5'd8;
        #1;
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_timer", {31'b0, timer_int}, 32'h0);
        chk("rst_flush", {31'b0, flush}, 32'h0);
        chk("rst_badv", rdata, 32'h0);
        clr();

        // syscall, not in delay slot
        pc = 32'h8000_0100; syscall = 1; #1;
        chk("sys_flush", {31'b0, flush}, 32'h1);
        chk("sys_newpc", newpc, 32'hBFC0_0380);
        edge_(); clr(); #1;
        chk("sys_epc", epc_o, 32'h8000_0100);
        chk("sys_code", {27'b0, cause_o[6:2]}, 32'h08);
        chk("sys_exl", {31'b0, status_o[1]}, 32'h1);

        // eret back to 8000_0100
        eret = 1; #1;
        chk("eret_flush", {31'b0, flush}, 32'h1);
        chk("eret_newpc", newpc, 32'h8000_0100);
        edge_(); clr(); #1;
        chk("eret_exl", {31'b0, status_o[1]}, 32'h0);

        // store address error in a delay slot
        ades = 1; bad_addr = 32'h1234_5673; pc = 32'h8000_0200; in_delay_slot = 1;
        edge_(); clr(); raddr = 5'd8; #1;
        chk("ades_epc", epc_o, 32'h8000_01FC);
        chk("ades_bd", {31'b0, cause_o[31]}, 32'h1);
        chk("ades_code", {27'b0, cause_o[6:2]}, 32'h05);
        chk("ades_badv", rdata, 32'h1234_5673);
        clr();

        eret = 1; #1;
        chk("eret2_newpc", newpc, 32'h8000_01FC);
        edge_(); clr();

        // ri and ov together: ri wins
        ri = 1; ov = 1; pc = 32'h8000_0400;
        edge_(); clr(); #1;
        chk("riov_code", {27'b0, cause_o[6:2]}, 32'h0a);
        chk("riov_epc", epc_o, 32'h8000_0400);
        chk("riov_bd", {31'b0, cause_o[31]}, 32'h0);
        // again with EXL already set: EPC held
        ri = 1; ov = 1; pc = 32'h8000_0500;
        edge_(); clr(); #1;
        chk("riov2_code", {27'b0, cause_o[6:2]}, 32'h0a);
        chk("riov2_epc", epc_o, 32'h8000_0400);

        // eret with breakM: the exception wins
        eret = 1; breakM = 1; pc = 32'h8000_0550; #1;
        chk("eretbp_flush", {31'b0, flush}, 32'h1);
        chk("eretbp_newpc", newpc, 32'hBFC0_0380);
        edge_(); clr(); #1;
        chk("eretbp_code", {27'b0, cause_o[6:2]}, 32'h09);
        chk("eretbp_epc", epc_o, 32'h8000_0400);

        // MTC0 EPC with same-cycle MFC0 forwarding
        cp0we = 1; waddr = 5'd14; wdata = 32'h8000_1000; raddr = 5'd14; #1;
        chk("fwd_rdata", rdata, 32'h8000_1000);
        edge_(); clr(); #1;
        chk("fwd_epc", epc_o, 32'h8000_1000);

        // only writable Status/Cause bits change
        mtc0(5'd12, 32'hFFFF_FFFF); #1;
        chk("status_wmask", status_o, 32'h0040_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF); #1;
        chk("cause_wmask", cause_o, 32'h0000_0324);

        // software interrupt IP[0] unmasked with EXL cleared
        mtc0(5'd12, 32'h0000_0101);
        pc = 32'h8000_0600; #1;
        chk("swint_flush", {31'b0, flush}, 32'h1);
        chk("swint_newpc", newpc, 32'hBFC0_0380);
        edge_(); clr(); #1;
        chk("swint_code", {27'b0, cause_o[6:2]}, 32'h00);
        chk("swint_epc", epc_o, 32'h8000_0600);
        mtc0(5'd13, 32'h0);

        // hardware line lands in IP[7]
        int_hw = 6'h20;
        edge_(); #1;
        chk("hwint_ip7", {31'b0, cause_o[15]}, 32'h1);
        clr(); edge_(); #1;
        chk("hwint_ip7_off", {31'b0, cause_o[15]}, 32'h0);

        // stall holds everything, then reset mid-stall and with a pending flush
        stall = 1; syscall = 1; cp0we = 1; waddr = 5'd14; wdata = 32'hDEAD_BEEF; #1;
        chk("stall_flush", {31'b0, flush}, 32'h0);
        edge_(); #1;
        chk("stall_epc", epc_o, 32'h8000_0600);
        chk("stall_status", status_o, 32'h0040_0103);
        edge_();
        rst = 1;
        edge_(); #1;
        chk("rst2_status", status_o, 32'h0040_0000);
        chk("rst2_epc", epc_o, 32'h0);
        stall = 0;
        edge_();
        rst = 0; clr(); raddr = 5'd8; #1;
        chk("rst3_epc", epc_o, 32'h0);
        chk("rst3_cause", cause_o, 32'h0);
        chk("rst3_badv", rdata, 32'h0);
        clr();

`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'd5);
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'd0);
        repeat (10) edge_();
        chk("timer_before", {31'b0, timer_int}, 32'h0);
        edge_();
        chk("timer_set", {31'b0, timer_int}, 32'h1);
        pc = 32'h8000_0700;
        got = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (flush) begin got = 1; edge_(); break; end
            edge_();
        end
        chk("timer_flush_seen", {31'b0, got}, 32'h1);
        clr(); #1;
        chk("timer_code", {27'b0, cause_o[6:2]}, 32'h00);
        chk("timer_epc", epc_o, 32'h8000_0700);
        mtc0(5'd11, 32'h0000_1000);
        raddr = 5'd11; #1;
        chk("timer_clr", {31'b0, timer_int}, 32'h0);
        chk("compare_rd", rdata, 32'h0000_1000);
        clr();
`else
        cp0we = 1; waddr = 5'd9; wdata = 32'h55; raddr = 5'd9; #1;
        chk("count_nofwd", rdata, 32'h0);
        edge_(); clr(); raddr = 5'd9; #1;
        chk("count_zero", rdata, 32'h0);
        mtc0(5'd11, 32'h7); raddr = 5'd11; #1;
        chk("compare_zero", rdata, 32'h0);
        chk("notimer_int", {31'b0, timer_int}, 32'h0);
        clr();
`endif
        edge_(); edge_();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
